// File: rtl/spgd_pkg.sv
// Shared SPGD definitions: FSM encoding and default datapath widths.
// Also used by the RNG stage so delta widths stay consistent.
package spgd_pkg;

    localparam int SPGD_OUT_WIDTH  = 12;
    localparam int SPGD_U_WIDTH    = 16;
    localparam int SPGD_J_WIDTH    = 16;
    localparam int SPGD_GAIN_SHIFT = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_P_WAIT = 3'd1,
        S_M_SET  = 3'd2,
        S_M_WAIT = 3'd3,
        S_UPDATE = 3'd4
    } spgd_state_t;

    function automatic int spgd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spgd_sat_add.sv
// Signed saturating add: W-bit operand plus a signed addend of any width.
// Result clamps to the W-bit two's-complement range instead of wrapping.
module spgd_sat_add
    import spgd_pkg::*;
#(
    parameter int W       = 16,
    parameter int A_WIDTH = 13
) (
    input  logic signed [W-1:0]       i_a,
    input  logic signed [A_WIDTH-1:0] i_b,
    output logic signed [W-1:0]       o_sum
);

    localparam int S = spgd_max(W, A_WIDTH) + 1;

    logic signed [S-1:0] w_a;
    logic signed [S-1:0] w_b;
    logic signed [S-1:0] w_sum;
    logic signed [S-1:0] w_max;
    logic signed [S-1:0] w_min;

    assign w_a   = {{(S-W){i_a[W-1]}}, i_a};
    assign w_b   = {{(S-A_WIDTH){i_b[A_WIDTH-1]}}, i_b};
    assign w_sum = w_a + w_b;
    assign w_max = {{(S-W+1){1'b0}}, {(W-1){1'b1}}};
    assign w_min = {{(S-W+1){1'b1}}, {(W-1){1'b0}}};

    always_comb begin
        o_sum = w_sum[W-1:0];
        if (w_sum > w_max) begin
            o_sum = w_max[W-1:0];
        end else if (w_sum < w_min) begin
            o_sum = w_min[W-1:0];
        end
    end

endmodule

// File: rtl/spgd_perturb_update.sv
// One SPGD iteration: apply +delta, measure, apply -delta, measure,
// then step the control word by the scaled metric difference.
module spgd_perturb_update
    import spgd_pkg::*;
#(
    parameter int OUT_WIDTH  = SPGD_OUT_WIDTH,
    parameter int U_WIDTH    = SPGD_U_WIDTH,
    parameter int J_WIDTH    = SPGD_J_WIDTH,
    parameter int GAIN_SHIFT = SPGD_GAIN_SHIFT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [OUT_WIDTH-1:0] delta_in,
    input  logic                        load,
    input  logic signed [U_WIDTH-1:0]   u_load_val,
    input  logic                        meas_valid,
    input  logic [J_WIDTH-1:0]          meas_j,
    output logic signed [U_WIDTH-1:0]   u_out,
    output logic                        meas_req,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 iter_cnt
);

    localparam int DW = OUT_WIDTH + 1;
    localparam int PW = J_WIDTH + OUT_WIDTH + 1;

    spgd_state_t r_state;
    spgd_state_t w_next;

    logic signed [U_WIDTH-1:0]   r_u;
    logic signed [U_WIDTH-1:0]   r_u_out;
    logic signed [OUT_WIDTH-1:0] r_delta;
    logic [J_WIDTH-1:0]          r_jp;
    logic [J_WIDTH-1:0]          r_jm;
    logic                        r_meas_req;
    logic                        r_done;
    logic [15:0]                 r_iter;

    logic                        w_valid;
    logic signed [DW-1:0]        w_din_x;
    logic signed [DW-1:0]        w_dr_neg;
    logic signed [DW-1:0]        w_pert_add;
    logic signed [U_WIDTH-1:0]   w_pert_sum;
    logic signed [J_WIDTH:0]     w_dj;
    logic signed [PW-1:0]        w_dj_x;
    logic signed [PW-1:0]        w_dr_x;
    logic signed [PW-1:0]        w_prod;
    logic signed [PW-1:0]        w_step;
    logic signed [U_WIDTH-1:0]   w_upd_sum;

    // A sample only counts while we are actually asking for one
    assign w_valid = meas_valid & r_meas_req;

    // IDLE uses the incoming delta directly; P_WAIT subtracts the stored one
    assign w_din_x    = {delta_in[OUT_WIDTH-1], delta_in};
    assign w_dr_neg   = -{r_delta[OUT_WIDTH-1], r_delta};
    assign w_pert_add = (r_state == S_IDLE) ? w_din_x : w_dr_neg;

    spgd_sat_add #(
        .W       (U_WIDTH),
        .A_WIDTH (DW)
    ) u_pert_add (
        .i_a   (r_u),
        .i_b   (w_pert_add),
        .o_sum (w_pert_sum)
    );

    assign w_dj   = {1'b0, r_jp} - {1'b0, r_jm};
    assign w_dj_x = {{OUT_WIDTH{w_dj[J_WIDTH]}}, w_dj};
    assign w_dr_x = {{(J_WIDTH+1){r_delta[OUT_WIDTH-1]}}, r_delta};
    assign w_prod = w_dj_x * w_dr_x;
    assign w_step = w_prod >>> GAIN_SHIFT;

    spgd_sat_add #(
        .W       (U_WIDTH),
        .A_WIDTH (PW)
    ) u_upd_add (
        .i_a   (r_u),
        .i_b   (w_step),
        .o_sum (w_upd_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !load) begin
                    w_next = S_P_WAIT;
                end
            end
            S_P_WAIT: begin
                if (w_valid) begin
                    w_next = S_M_SET;
                end
            end
            S_M_SET: begin
                w_next = S_M_WAIT;
            end
            S_M_WAIT: begin
                if (w_valid) begin
                    w_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_u        <= '0;
            r_u_out    <= '0;
            r_delta    <= '0;
            r_jp       <= '0;
            r_jm       <= '0;
            r_meas_req <= 1'b0;
            r_done     <= 1'b0;
            r_iter     <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // load wins over start when both arrive together
                    if (load) begin
                        r_u     <= u_load_val;
                        r_u_out <= u_load_val;
                    end else if (start) begin
                        r_delta    <= delta_in;
                        r_u_out    <= w_pert_sum;
                        r_meas_req <= 1'b1;
                    end
                end
                S_P_WAIT: begin
                    if (w_valid) begin
                        r_jp       <= meas_j;
                        r_u_out    <= w_pert_sum;
                        r_meas_req <= 1'b0;
                    end
                end
                S_M_SET: begin
                    r_meas_req <= 1'b1;
                end
                S_M_WAIT: begin
                    if (w_valid) begin
                        r_jm       <= meas_j;
                        r_meas_req <= 1'b0;
                    end
                end
                S_UPDATE: begin
                    r_u     <= w_upd_sum;
                    r_u_out <= w_upd_sum;
                    r_done  <= 1'b1;
                    r_iter  <= r_iter + 16'd1;
                end
                default: begin
                    r_meas_req <= 1'b0;
                end
            endcase
        end
    end

    assign u_out    = r_u_out;
    assign meas_req = r_meas_req;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign iter_cnt = r_iter;

endmodule

// File: tb/tb_spgd_perturb_update.sv
// Bench for spgd_perturb_update: transaction-level model checked every
// cycle, plus literal expectations for the worked scenarios.
module tb_spgd_perturb_update;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               start;
    logic signed [11:0] delta_in;
    logic               load;
    logic signed [15:0] u_load_val;
    logic               meas_valid;
    logic [15:0]        meas_j;
    logic signed [15:0] u_out;
    logic               meas_req;
    logic               busy;
    logic               done;
    logic [15:0]        iter_cnt;

    spgd_perturb_update dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .delta_in   (delta_in),
        .load       (load),
        .u_load_val (u_load_val),
        .meas_valid (meas_valid),
        .meas_j     (meas_j),
        .u_out      (u_out),
        .meas_req   (meas_req),
        .busy       (busy),
        .done       (done),
        .iter_cnt   (iter_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int done_cyc = -1;

    // model of what the outputs must be after the latest edge
    int m_u, m_uout, m_iter;
    bit m_req, m_busy, m_done;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic longint floor_div16(input longint p);
        longint q;
        q = p / 16;
        if ((p % 16 != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("u_out", int'(u_out), m_uout);
            chk("meas_req", int'(meas_req), int'(m_req));
            chk("busy", int'(busy), int'(m_busy));
            chk("done", int'(done), int'(m_done));
            chk("iter_cnt", int'(iter_cnt), m_iter);
            if (done) done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        m_done = 1'b0;
    endtask

    task automatic do_load(input int v, input bit with_start);
        load       = 1'b1;
        u_load_val = 16'(v);
        start      = with_start;
        delta_in   = 12'sd77;
        tick();
        load  = 1'b0;
        start = 1'b0;
        m_u    = v;
        m_uout = v;
    endtask

    task automatic iter(input int d, input int jp, input int jm,
                        input int dp, input int dm, input bit noise,
                        input int exp_lat, output int got_p, output int got_m);
        int sc;
        delta_in = 12'(d);
        start    = 1'b1;
        sc       = cyc;
        tick();
        start  = 1'b0;
        m_uout = sat16(longint'(m_u) + d);
        m_req  = 1'b1;
        m_busy = 1'b1;
        got_p  = int'(u_out);
        for (int i = 0; i < dp; i++) begin
            if (noise) begin
                start      = 1'b1;
                load       = 1'b1;
                u_load_val = 16'sd1234;
                delta_in   = -12'sd5;
            end
            tick();
        end
        start      = 1'b0;
        load       = 1'b0;
        meas_valid = 1'b1;
        meas_j     = 16'(jp);
        tick();
        m_uout = sat16(longint'(m_u) - d);
        m_req  = 1'b0;
        got_m  = int'(u_out);
        meas_valid = noise;
        meas_j     = 16'd9999;
        start      = noise;
        tick();
        m_req = 1'b1;
        for (int i = 0; i < dm; i++) begin
            meas_valid = 1'b0;
            start      = noise;
            tick();
        end
        meas_valid = 1'b1;
        meas_j     = 16'(jm);
        start      = 1'b0;
        tick();
        m_req = 1'b0;
        meas_valid = noise;
        meas_j     = 16'd5;
        start      = noise;
        tick();
        m_u    = sat16(longint'(m_u) + floor_div16(longint'(jp - jm) * d));
        m_uout = m_u;
        m_done = 1'b1;
        m_busy = 1'b0;
        m_iter = (m_iter + 1) & 32'hFFFF;
        start      = 1'b0;
        meas_valid = 1'b0;
        tick();
        chk("latency", done_cyc - sc, exp_lat);
    endtask

    int p, m;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        load       = 1'b0;
        meas_valid = 1'b0;
        delta_in   = '0;
        u_load_val = '0;
        meas_j     = '0;
        m_u = 0; m_uout = 0; m_iter = 0;
        m_req = 0; m_busy = 0; m_done = 0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // metric strobes with no request outstanding
        meas_valid = 1'b1;
        meas_j     = 16'd4000;
        tick();
        tick();
        meas_valid = 1'b0;

        // basic update
        iter(100, 300, 200, 0, 0, 1'b0, 5, p, m);
        chk("basic_p", p, 100);
        chk("basic_m", m, -100);
        chk("basic_u", int'(u_out), 625);
        chk("basic_iter", int'(iter_cnt), 1);

        // negative delta
        do_load(0, 1'b0);
        iter(-64, 100, 180, 0, 0, 1'b0, 5, p, m);
        chk("negd_p", p, -64);
        chk("negd_u", int'(u_out), 320);

        // floor rounding of a negative step
        do_load(0, 1'b0);
        iter(1, 0, 17, 0, 0, 1'b0, 5, p, m);
        chk("floor_u", int'(u_out), -2);

        // positive saturation
        do_load(32700, 1'b0);
        iter(100, 1000, 0, 0, 0, 1'b0, 5, p, m);
        chk("satp_p", p, 32767);
        chk("satp_m", m, 32600);
        chk("satp_u", int'(u_out), 32767);

        // negative saturation
        do_load(-32700, 1'b0);
        iter(-100, 1000, 0, 0, 0, 1'b0, 5, p, m);
        chk("satn_p", p, -32768);
        chk("satn_u", int'(u_out), -32768);

        // load and start together: start dropped
        do_load(-500, 1'b1);
        tick();
        chk("ldst_u", int'(u_out), -500);
        chk("ldst_busy", int'(busy), 0);

        // delayed metric, noise on start/load/meas_valid while busy
        iter(10, 400, 100, 9, 0, 1'b1, 14, p, m);
        chk("delay_iter", int'(iter_cnt), 6);
        iter(-20, 50, 90, 2, 3, 1'b1, 10, p, m);

        // reset in M_WAIT, with competing inputs
        delta_in = 12'sd50;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        m_uout = sat16(longint'(m_u) + 50);
        m_req  = 1'b1;
        m_busy = 1'b1;
        meas_valid = 1'b1;
        meas_j     = 16'd10;
        tick();
        m_uout = sat16(longint'(m_u) - 50);
        m_req  = 1'b0;
        meas_valid = 1'b0;
        tick();
        m_req = 1'b1;
        rst        = 1'b1;
        start      = 1'b1;
        load       = 1'b1;
        meas_valid = 1'b1;
        tick();
        m_u = 0; m_uout = 0; m_iter = 0;
        m_req = 0; m_busy = 0;
        chk("rst_u", int'(u_out), 0);
        chk("rst_iter", int'(iter_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        rst        = 1'b0;
        start      = 1'b0;
        load       = 1'b0;
        meas_valid = 1'b0;
        tick();

        iter(100, 300, 200, 0, 0, 1'b0, 5, p, m);
        chk("post_p", p, 100);
        chk("post_m", m, -100);
        chk("post_u", int'(u_out), 625);
        chk("post_iter", int'(iter_cnt), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
